// File: rtl/avst_fifo_reader_if.sv
// avst_fifo_reader_if: FIFO read port and Avalon-ST source bundle for the FIFO drain engine.
interface avst_fifo_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    // FIFO read side (CLK0 domain)
    logic [DATA_WIDTH-1:0] fifo_q;
    logic                  fifo_empty;
    logic                  fifo_deq;

    // Avalon-ST source
    logic [DATA_WIDTH-3:0] out_data;
    logic                  out_sop;
    logic                  out_eop;
    logic                  out_valid;
    logic                  out_ready;

    // Status
    logic                  err_orphan;
    logic                  err_trunc;
    logic [CNT_WIDTH-1:0]  pkt_cnt;

    // The drain engine.
    modport master (
        input  fifo_q, fifo_empty, out_ready,
        output fifo_deq, out_data, out_sop, out_eop, out_valid,
               err_orphan, err_trunc, pkt_cnt
    );

    // FIFO plus downstream sink.
    modport slave (
        output fifo_q, fifo_empty, out_ready,
        input  fifo_deq, out_data, out_sop, out_eop, out_valid,
               err_orphan, err_trunc, pkt_cnt
    );
endinterface

// File: rtl/avst_fifo_reader.sv
// avst_fifo_reader: drains a BRAM dual-clock FIFO (one-cycle read latency) into an
// Avalon-ST source through a 2-entry buffer, filtering packet framing from the
// in-band SOP/EOP flags and counting packets delivered to the sink.
module avst_fifo_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input logic                CLK,
    input logic                RST,
    avst_fifo_reader_if.master bus
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] IN_PKT = 1'b1;

    logic [0:0]            state;
    logic [1:0]            occ;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] ent0;
    logic [DATA_WIDTH-1:0] ent1;

    logic [DATA_WIDTH-1:0] word;
    logic                  w_sop;
    logic                  w_eop;
    logic                  push;
    logic                  handshake;
    logic [1:0]            committed;

    // Landing-word decode, handshake and pop decision; buffer slots plus words
    // in flight never exceed two, and a same-cycle sink handshake frees a slot.
    always_comb begin
        word          = bus.fifo_q;
        w_sop         = word[DATA_WIDTH-1];
        w_eop         = word[DATA_WIDTH-2];
        push          = inflight && ((state == IN_PKT) || w_sop);
        handshake     = (occ != 2'd0) && bus.out_ready;
        committed     = occ + {1'b0, inflight};
        bus.fifo_deq  = !RST && !bus.fifo_empty && ((committed < 2'd2) || handshake);
        bus.out_valid = (occ != 2'd0);
        bus.out_data  = ent0[DATA_WIDTH-3:0];
        bus.out_sop   = ent0[DATA_WIDTH-1];
        bus.out_eop   = ent0[DATA_WIDTH-2];
    end

    // A pop this cycle means fifo_q carries a word next cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight <= 1'b0;
        end else begin
            inflight <= bus.fifo_deq;
        end
    end

    // Framing filter on each landing word; error pulses align with the buffer write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            bus.err_orphan <= 1'b0;
            bus.err_trunc  <= 1'b0;
        end else begin
            bus.err_orphan <= inflight && (state == IDLE) && !w_sop;
            bus.err_trunc  <= inflight && (state == IN_PKT) && w_sop;
            if (push) begin
                state <= w_eop ? IDLE : IN_PKT;
            end
        end
    end

    // Shift-structured 2-entry buffer: ent0 is always the head presented to the sink.
    always_ff @(posedge CLK) begin
        if (RST) begin
            occ  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            case ({handshake, push})
                2'b01: begin
                    if (occ == 2'd0) begin
                        ent0 <= word;
                    end else begin
                        ent1 <= word;
                    end
                    occ <= occ + 2'd1;
                end
                2'b10: begin
                    ent0 <= ent1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        ent0 <= ent1;
                        ent1 <= word;
                    end else begin
                        ent0 <= word;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Packet counter advances on every EOP beat the sink accepts; wraps silently.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.pkt_cnt <= '0;
        end else if (handshake && ent0[DATA_WIDTH-2]) begin
            bus.pkt_cnt <= bus.pkt_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: tb/tb_avst_fifo_reader.sv
// tb_avst_fifo_reader: directed scoreboard bench for avst_fifo_reader.
module tb_avst_fifo_reader;
    localparam int DW = 32;
    localparam int CW = 2;
    localparam logic [31:0] SOP = 32'h8000_0000;
    localparam logic [31:0] EOP = 32'h4000_0000;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic hold_ne = 1'b1;

    always #5 CLK = ~CLK;

    avst_fifo_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    avst_fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int deq_cnt = 0;
    int deq_bad = 0;
    int orphan_cnt = 0;
    int trunc_cnt = 0;

    logic [31:0] fq[$];
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: registered Q, registered (conservative) EMPTY, cleared by its RST0.
    always @(posedge CLK) begin
        if (RST) begin
            fq.delete();
            bus.fifo_empty <= !hold_ne;
        end else begin
            if (bus.fifo_deq && fq.size() > 0) bus.fifo_q <= fq.pop_front();
            bus.fifo_empty <= (fq.size() == 0);
        end
    end

    // Monitor: scoreboard compare on each sink handshake, plus event counters.
    always @(negedge CLK) begin
        logic [31:0] e;
        if (bus.fifo_deq) deq_cnt++;
        if (bus.fifo_deq && (RST || bus.fifo_empty)) deq_bad++;
        if (bus.err_orphan) orphan_cnt++;
        if (bus.err_trunc) trunc_cnt++;
        if (!RST && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL beat: unexpected beat %0h, expected none at %0t",
                         {bus.out_sop, bus.out_eop, bus.out_data}, $time);
            end else begin
                e = exp_q.pop_front();
                check("beat", {bus.out_sop, bus.out_eop, bus.out_data}, e);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [31:0] w, input bit delivered);
        fq.push_back(w);
        if (delivered) exp_q.push_back(w);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        exp_q.delete();
        tick();
        RST = 1'b0;
        orphan_cnt = 0;
        trunc_cnt = 0;
        deq_cnt = 0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_found;
        int exp_wrap[5] = '{1, 2, 3, 0, 1};

        // Reset: three cycles with FIFO reporting non-empty.
        bus.out_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1 hold_ne = 1'b0;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_sop", 32'(bus.out_sop), 0);
        check("rst_eop", 32'(bus.out_eop), 0);
        check("rst_data", 32'(bus.out_data), 0);
        check("rst_orphan", 32'(bus.err_orphan), 0);
        check("rst_trunc", 32'(bus.err_trunc), 0);
        check("rst_pkt", 32'(bus.pkt_cnt), 0);

        // Streaming at full rate.
        tick();
        bus.out_ready = 1'b1;
        load(SOP | 32'hA0, 1'b1);
        load(32'hA1, 1'b1);
        load(32'hA2, 1'b1);
        load(EOP | 32'hA3, 1'b1);
        t_found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus.fifo_deq) begin
                t_found = 1;
                break;
            end
        end
        check("stream_start", t_found, 1);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge CLK);
            check("stream_deq", 32'(bus.fifo_deq), (k < 4) ? 1 : 0);
            check("stream_valid", 32'(bus.out_valid), (k >= 2 && k <= 5) ? 1 : 0);
        end
        check("stream_pkt", 32'(bus.pkt_cnt), 1);

        // Backpressure: sink stalled, only two pops may occur.
        tick();
        bus.out_ready = 1'b0;
        do_reset();
        load(SOP | 32'hA0, 1'b1);
        load(32'hA1, 1'b1);
        load(32'hA2, 1'b1);
        load(EOP | 32'hA3, 1'b1);
        repeat (12) @(negedge CLK);
        check("bp_deq_count", deq_cnt, 2);
        check("bp_valid", 32'(bus.out_valid), 1);
        check("bp_hold", 32'(bus.out_data), 32'hA0);
        tick();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("bp_nogap", 32'(bus.out_valid), 1);
        end
        wait_drain("bp");
        check("bp_pkt", 32'(bus.pkt_cnt), 1);

        // Orphan word dropped.
        do_reset();
        load(32'h55, 1'b0);
        load(SOP | EOP | 32'h66, 1'b1);
        wait_drain("orphan");
        check("orphan_pulse", orphan_cnt, 1);
        check("orphan_trunc", trunc_cnt, 0);
        check("orphan_pkt", 32'(bus.pkt_cnt), 1);

        // Truncated packet restarts.
        do_reset();
        load(SOP | 32'h1, 1'b1);
        load(32'h2, 1'b1);
        load(SOP | 32'h3, 1'b1);
        load(EOP | 32'h4, 1'b1);
        wait_drain("trunc");
        check("trunc_pulse", trunc_cnt, 1);
        check("trunc_orphan", orphan_cnt, 0);
        check("trunc_pkt", 32'(bus.pkt_cnt), 1);

        // Counter wrap with a 2-bit counter.
        do_reset();
        for (int p = 0; p < 5; p++) begin
            load(SOP | EOP | (32'h30 + 32'(p)), 1'b1);
            wait_drain("wrap");
            check("wrap_pkt", 32'(bus.pkt_cnt), 32'(exp_wrap[p]));
            tick();
        end

        // Reset mid-packet with a full buffer.
        bus.out_ready = 1'b0;
        load(SOP | 32'h10, 1'b0);
        load(32'h11, 1'b0);
        load(32'h12, 1'b0);
        load(EOP | 32'h13, 1'b0);
        repeat (6) @(negedge CLK);
        check("mid_valid_before", 32'(bus.out_valid), 1);
        tick();
        RST = 1'b1;
        exp_q.delete();
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("mid_valid_after", 32'(bus.out_valid), 0);
        check("mid_pkt_after", 32'(bus.pkt_cnt), 0);
        tick();
        bus.out_ready = 1'b1;
        load(SOP | 32'h20, 1'b1);
        load(EOP | 32'h21, 1'b1);
        wait_drain("post_rst");
        check("post_rst_pkt", 32'(bus.pkt_cnt), 1);

        check("deq_rule", deq_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
